// File: rtl/prog_ctr.sv
// prog_ctr: program counter stage. Selects a program start address on a run
// request, then advances by +1, PC-relative branch or absolute jump on each
// enabled cycle. Retires a halt with a one-cycle Done pulse and keeps a
// saturating retired-instruction count for the current run.
module prog_ctr #(
  parameter int          PC_W        = 10,
  parameter int          OFF_W       = 8,
  parameter int unsigned PROG1_START = 0,
  parameter int unsigned PROG2_START = 256,
  parameter int unsigned PROG3_START = 512
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             CountEn,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             BranchAbs,
  input  logic [PC_W-1:0]  Target,
  input  logic [OFF_W-1:0] Offset,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic             Fault,
  output logic [15:0]      InstrCount
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [PC_W-1:0]        r_pc, w_pc_nxt, w_start_pc, w_pc_inc, w_pc_rel;
  logic signed [PC_W-1:0] w_off_ext;
  logic [15:0]            r_cnt, w_cnt_nxt, w_cnt_sat;
  logic                   r_done, w_done_nxt;
  logic                   r_fault, w_fault_nxt;
  logic                   w_sel_ok;

  // ProgSel 3 has no program behind it; it is reported through Fault.
  assign w_sel_ok  = (ProgSel != 2'd3);
  assign w_off_ext = {{(PC_W-OFF_W){Offset[OFF_W-1]}}, Offset};
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_pc_rel  = r_pc + w_off_ext;
  assign w_cnt_sat = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  // Map the program select onto its start address.
  always_comb begin
    w_start_pc = PC_W'(PROG1_START);
    case (ProgSel)
      2'd1:    w_start_pc = PC_W'(PROG2_START);
      2'd2:    w_start_pc = PC_W'(PROG3_START);
      default: w_start_pc = PC_W'(PROG1_START);
    endcase
  end

  // Next-state and datapath update: run request first, then halt > branch > +1.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = r_fault;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_RUN: begin
        if (Start) begin
          // A run request (including an abort from RUN) reloads the program.
          if (w_sel_ok) begin
            w_state_nxt = S_ARMED;
            w_pc_nxt    = w_start_pc;
            w_cnt_nxt   = 16'd0;
            w_fault_nxt = 1'b0;
          end else begin
            w_fault_nxt = 1'b1;
          end
        end else if ((r_state == S_RUN) && CountEn) begin
          w_cnt_nxt = w_cnt_sat;
          if (Halt) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else if (BranchEn) begin
            w_pc_nxt = BranchAbs ? Target : w_pc_rel;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end
      S_ARMED: begin
        if (!Start) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // PC, count, fault and done-pulse registers.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc    <= '0;
      r_cnt   <= '0;
      r_fault <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_fault_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign PC         = r_pc;
  assign Running    = (r_state == S_RUN);
  assign Done       = r_done;
  assign Fault      = r_fault;
  assign InstrCount = r_cnt;

endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr: vector table for the directed scenarios, hand sequences for
// async reset and illegal select from IDLE, and random stimulus against a
// behavioural model of the program counter.
module tb_prog_ctr;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       Start;
  logic [1:0] ProgSel;
  logic       CountEn, Halt, BranchEn, BranchAbs;
  logic [9:0] Target;
  logic [7:0] Offset;
  logic [9:0] PC;
  logic       Running, Done, Fault;
  logic [15:0] InstrCount;

  int total = 0;
  int bad   = 0;

  prog_ctr dut (
    .clk(clk), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel),
    .CountEn(CountEn), .Halt(Halt), .BranchEn(BranchEn), .BranchAbs(BranchAbs),
    .Target(Target), .Offset(Offset), .PC(PC), .Running(Running),
    .Done(Done), .Fault(Fault), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [1:0] sel;
    logic       cen, halt, ben, babs;
    int         tgt;
    int         off;
    int         pc;
    logic       run, done, fault;
    int         cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t V(logic start, int sel, logic cen, logic halt, logic ben,
                             logic babs, int tgt, int off, int pc, logic run,
                             logic done, logic fault, int cnt);
    vec_t v;
    v.start = start; v.sel = 2'(sel); v.cen = cen; v.halt = halt;
    v.ben = ben; v.babs = babs; v.tgt = tgt; v.off = off;
    v.pc = pc; v.run = run; v.done = done; v.fault = fault; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int pc, input int run,
                         input int done, input int fault, input int cnt);
    chk({nm, "_pc"},    int'(PC),         pc);
    chk({nm, "_run"},   int'(Running),    run);
    chk({nm, "_done"},  int'(Done),       done);
    chk({nm, "_fault"}, int'(Fault),      fault);
    chk({nm, "_cnt"},   int'(InstrCount), cnt);
  endtask

  task automatic drive(input logic start, input int sel, input logic cen, input logic halt,
                       input logic ben, input logic babs, input int tgt, input int off);
    Start = start; ProgSel = 2'(sel); CountEn = cen; Halt = halt;
    BranchEn = ben; BranchAbs = babs; Target = 10'(tgt); Offset = 8'(off);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: run phases and plain modular arithmetic on the address.
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;
  int m_mode, m_pc, m_cnt, m_fault, m_done;
  int starts[3] = '{0, 256, 512};

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_fault = 0; m_done = 0;
  endtask

  task automatic model_step();
    int off;
    m_done = 0;
    if (Start && m_mode != M_ARMED) begin
      if (ProgSel == 2'd3) m_fault = 1;
      else begin
        m_mode = M_ARMED; m_pc = starts[ProgSel]; m_cnt = 0; m_fault = 0;
      end
    end else if (m_mode == M_ARMED) begin
      if (!Start) m_mode = M_RUN;
    end else if (m_mode == M_RUN && CountEn) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (Halt) begin
        m_mode = M_DONE; m_done = 1;
      end else if (BranchEn && BranchAbs) m_pc = Target;
      else if (BranchEn) begin
        off  = (Offset >= 128) ? int'(Offset) - 256 : int'(Offset);
        m_pc = (m_pc + off + 1024) % 1024;
      end else m_pc = (m_pc + 1) % 1024;
    end
  endtask

  initial begin
    // start sel cen halt ben babs tgt off | pc run done fault cnt
    vt.push_back(V(1, 1, 1, 0, 0, 0,    0,    0,  256, 0, 0, 0, 0));
    vt.push_back(V(1, 1, 1, 0, 0, 0,    0,    0,  256, 0, 0, 0, 0));
    vt.push_back(V(0, 1, 1, 0, 0, 0,    0,    0,  256, 1, 0, 0, 0));
    vt.push_back(V(0, 1, 1, 0, 0, 0,    0,    0,  257, 1, 0, 0, 1));
    vt.push_back(V(0, 1, 1, 0, 0, 0,    0,    0,  258, 1, 0, 0, 2));
    vt.push_back(V(0, 1, 1, 0, 1, 1,  300,    0,  300, 1, 0, 0, 3));
    vt.push_back(V(0, 1, 1, 0, 1, 0,    0, 'hFB,  295, 1, 0, 0, 4));
    vt.push_back(V(0, 1, 1, 0, 1, 1,  700,    0,  700, 1, 0, 0, 5));
    vt.push_back(V(0, 1, 1, 1, 1, 1,    5,    0,  700, 0, 1, 0, 6));
    vt.push_back(V(0, 1, 1, 0, 0, 0,    0,    0,  700, 0, 0, 0, 6));
    vt.push_back(V(0, 1, 1, 0, 1, 1,    9,    0,  700, 0, 0, 0, 6));
    vt.push_back(V(1, 3, 1, 0, 0, 0,    0,    0,  700, 0, 0, 1, 6));
    vt.push_back(V(0, 3, 1, 0, 0, 0,    0,    0,  700, 0, 0, 1, 6));
    vt.push_back(V(1, 0, 1, 0, 0, 0,    0,    0,    0, 0, 0, 0, 0));
    vt.push_back(V(0, 0, 1, 0, 0, 0,    0,    0,    0, 1, 0, 0, 0));
    vt.push_back(V(0, 0, 1, 0, 0, 0,    0,    0,    1, 1, 0, 0, 1));
    vt.push_back(V(0, 0, 1, 0, 0, 0,    0,    0,    2, 1, 0, 0, 2));
    vt.push_back(V(0, 0, 1, 0, 0, 0,    0,    0,    3, 1, 0, 0, 3));
    vt.push_back(V(0, 0, 1, 0, 0, 0,    0,    0,    4, 1, 0, 0, 4));
    vt.push_back(V(0, 0, 1, 1, 0, 0,    0,    0,    4, 0, 1, 0, 5));
    vt.push_back(V(0, 0, 1, 0, 0, 0,    0,    0,    4, 0, 0, 0, 5));
    vt.push_back(V(1, 2, 1, 0, 0, 0,    0,    0,  512, 0, 0, 0, 0));
    vt.push_back(V(0, 2, 1, 0, 0, 0,    0,    0,  512, 1, 0, 0, 0));
    vt.push_back(V(0, 2, 1, 0, 1, 1, 1023,    0, 1023, 1, 0, 0, 1));
    vt.push_back(V(0, 2, 1, 0, 0, 0,    0,    0,    0, 1, 0, 0, 2));
    vt.push_back(V(0, 2, 0, 0, 0, 0,    0,    0,    0, 1, 0, 0, 2));
    vt.push_back(V(0, 2, 0, 1, 1, 1,   77,    0,    0, 1, 0, 0, 2));
    vt.push_back(V(0, 2, 0, 0, 0, 0,    0,    0,    0, 1, 0, 0, 2));
    vt.push_back(V(0, 2, 1, 0, 1, 1,  600,    0,  600, 1, 0, 0, 3));
    vt.push_back(V(1, 2, 1, 1, 1, 1,   33,    0,  512, 0, 0, 0, 0));
    vt.push_back(V(0, 2, 1, 0, 0, 0,    0,    0,  512, 1, 0, 0, 0));
    vt.push_back(V(0, 2, 1, 0, 0, 0,    0,    0,  513, 1, 0, 0, 1));

    Reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    Reset_n = 1'b1;
    tick();
    chk_all("idle_after_reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].start, vt[i].sel, vt[i].cen, vt[i].halt,
            vt[i].ben, vt[i].babs, vt[i].tgt, vt[i].off);
      tick();
      chk_all($sformatf("v%0d", i), vt[i].pc, vt[i].run, vt[i].done,
              vt[i].fault, vt[i].cnt);
    end

    // Async reset between edges while running at PC=513.
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    #3;
    Reset_n = 1'b1;
    tick();
    tick();
    chk_all("post_reset_idle", 0, 0, 0, 0, 0);

    // Illegal select from IDLE, then a legal start clears Fault.
    drive(1, 3, 1, 0, 0, 0, 0, 0);
    tick();
    chk_all("illegal_idle", 0, 0, 0, 1, 0);
    drive(0, 3, 1, 0, 0, 0, 0, 0);
    tick();
    chk_all("illegal_hold", 0, 0, 0, 1, 0);
    drive(1, 2, 1, 0, 0, 0, 0, 0);
    tick();
    chk_all("legal_after_fault", 512, 0, 0, 0, 0);

    // Random stimulus against the model, starting from a clean reset.
    #2;
    Reset_n = 1'b0;
    model_reset();
    #2;
    Reset_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      logic st;
      int   sel;
      case (m_mode)
        M_RUN:   st = ($urandom_range(0, 39) == 0);
        M_ARMED: st = ($urandom_range(0, 1) == 0);
        default: st = ($urandom_range(0, 3) == 0);
      endcase
      sel = (m_mode == M_RUN) ? $urandom_range(0, 2) : $urandom_range(0, 3);
      drive(st, sel, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
            $urandom_range(0, 1023), $urandom_range(0, 255));
      model_step();
      tick();
      chk_all($sformatf("rnd%0d", c), m_pc, (m_mode == M_RUN), m_done, m_fault, m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
